future_rk_sel: RTL and testbench
================================

Name: future_rk_sel

Overview:
- Parametrised round-key selector for the FUTURE cipher datapath.
- Captures the master key, splits it into NUM_SUBKEYS subkeys, and presents one registered round key per round over a valid/ready handshake.
- Sits between key input and round function; generalises the fixed two-register K0/K1 select with configurable width, subkey count, round count, stall support and restart-on-reload.

Parameters:
- KEY_W, 128, master key width; must equal RK_W*NUM_SUBKEYS.
- RK_W, 64, round key width.
- NUM_SUBKEYS, 2, subkeys cycled through; subkey j = key_in[KEY_W-1-j*RK_W -: RK_W] (j=0 is most significant).
- NUM_ROUNDS, 10, round keys issued per key load.
- CNT_W, $clog2(NUM_ROUNDS+1), round counter width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- key_in  in  KEY_W  master key; sampled when key_load=1
- key_load  in  1  capture key_in and (re)start the sequence
- rk_ready  in  1  consumer accepts rk_out this cycle
- rk_out  out  RK_W  current round key (registered)
- rk_valid  out  1  rk_out is valid
- round_idx  out  CNT_W  0-based index of the round key on rk_out
- last_round  out  1  high while round_idx == NUM_ROUNDS-1 and rk_valid=1
- done  out  1  one-cycle pulse after the last round key is accepted
- busy  out  1  high in RUN state

Behaviour:
- Reset: synchronous, active-high, highest priority.
  - State goes to IDLE; subkey registers are zeroised.
  - All outputs are 0: rk_out, rk_valid, round_idx, last_round, done, busy.
- States:
  - IDLE: waiting for key_load.
  - RUN: issuing round keys.
  - DONE: one cycle, then IDLE.
- IDLE, key_load=1:
  - Subkeys are captured.
  - Next cycle: state RUN, rk_valid=1, round_idx=0, rk_out = RK_0. Latency key_load -> first valid key is 1 cycle.
- Round key: RK_i = SK[i mod NUM_SUBKEYS] XOR RC_i.
  - RC_i = (i+1) zero-extended in bits [CNT_W-1:0], zero elsewhere.
  - See the optional feature for when RC is applied.
- RUN, handshake (rk_valid & rk_ready), round_idx < NUM_ROUNDS-1:
  - Next cycle round_idx+1 and the corresponding rk_out.
  - Back-to-back acceptance gives one key per cycle.
- RUN, rk_ready=0: rk_out and round_idx hold stable (stall). rk_valid is never dropped without a handshake, except on rst or key_load.
- RUN, handshake at round_idx = NUM_ROUNDS-1:
  - Next cycle: state DONE, rk_valid=0, done=1, busy=0, round_idx returns to 0.
  - The following cycle returns to IDLE and done=0.
- key_load in RUN or DONE (restart):
  - The new key is captured and the sequence restarts at round 0 on the next cycle. Any in-flight key is discarded.
  - done is not asserted.
  - key_load wins over a simultaneous handshake.
- Subkey index wraps modulo NUM_SUBKEYS. Non-power-of-2 NUM_SUBKEYS is supported via a separate wrapping counter, not a slice of round_idx.
- NUM_ROUNDS=1: the first key carries last_round=1.
- rk_ready while rk_valid=0 is ignored.
- Subkey registers retain the key after DONE until the next key_load or rst.

Optional Feature:
- Macro: FUTURE_RK_RC_EN.
- Defined: RK_i = SK[i mod NUM_SUBKEYS] XOR RC_i as above.
- Undefined: RK_i = SK[i mod NUM_SUBKEYS] with no constant. The RC logic is not elaborated. Handshake and timing are identical.

Test Plan:
- Reset with key_in present and key_load=0 -> all outputs 0, rk_valid stays 0 for 10 cycles.
- FUTURE_RK_RC_EN defined, key_in=128'h0123456789ABCDEF_FEDCBA9876543210, key_load 1 cycle, rk_ready=1 constantly:
  - RK0=64'h0123456789ABCDEE, RK1=64'hFEDCBA9876543212, RK2=64'h0123456789ABCDEC.
  - RK9=64'hFEDCBA987654321A with last_round=1.
  - done pulses on the cycle after RK9.
- Same key, rk_ready deasserted for 3 cycles at round_idx=4 -> rk_out=64'h0123456789ABCDEA and round_idx=4 held stable, then the sequence resumes with no skipped or duplicated keys.
- Macro undefined, same key -> RK keys alternate 64'h0123456789ABCDEF and 64'hFEDCBA9876543210 for 10 rounds.
- key_load with key_in=128'h0 asserted at round_idx=6 together with rk_ready=1 -> next cycle round_idx=0 and rk_out=64'h0000000000000001 (macro defined); no done pulse.
- rst asserted at round_idx=3 -> next cycle all outputs 0 and state IDLE; the next key_load restarts at round 0.

Source files
------------

// File: rtl/future_rk_sel.sv
// Purpose : round-key selector; splits the master key into subkeys and issues one round key per round.
// Latency : key_load -> first valid round key is 1 cycle; one key per cycle under back-to-back acceptance.
// Backpressure: rk_ready low holds rk_out/round_idx stable; rk_valid only drops after a handshake, rst or key_load.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   key_in, key_load          master key and its capture strobe (also restarts a running sequence)
//   rk_out, rk_valid, rk_ready  registered round key with valid/ready handshake
//   round_idx, last_round     0-based index of rk_out, high on the final round key
//   done, busy                one-cycle completion pulse, high while issuing keys
//
// Optional feature macro: FUTURE_RK_RC_EN
//   defined   : RK_i = SK[i mod NUM_SUBKEYS] ^ (i+1) in the low CNT_W bits
//   undefined : RK_i = SK[i mod NUM_SUBKEYS], no round constant logic is built
module future_rk_sel #(
   parameter int KEY_W       = 128,
   parameter int RK_W        = 64,
   parameter int NUM_SUBKEYS = 2,
   parameter int NUM_ROUNDS  = 10,
   parameter int CNT_W       = $clog2(NUM_ROUNDS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [KEY_W-1:0] key_in,
   input  logic             key_load,
   input  logic             rk_ready,
   output logic [RK_W-1:0]  rk_out,
   output logic             rk_valid,
   output logic [CNT_W-1:0] round_idx,
   output logic             last_round,
   output logic             done,
   output logic             busy
);

   localparam int               SK_W     = (NUM_SUBKEYS > 1) ? $clog2(NUM_SUBKEYS) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_ROUNDS - 1);
   localparam logic [SK_W-1:0]  LAST_SK  = SK_W'(NUM_SUBKEYS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [RK_W-1:0]  sk [NUM_SUBKEYS];
   logic [SK_W-1:0]  sk_idx;
   logic [SK_W-1:0]  sk_nxt;
   logic             hs;
   logic             at_last;
   logic [RK_W-1:0]  rk_load_nxt;
   logic [RK_W-1:0]  rk_step_nxt;

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (key_load) state_nxt = S_RUN;
         end
         S_RUN: begin
            // key_load restarts and takes precedence over a final handshake
            if (key_load)            state_nxt = S_RUN;
            else if (hs && at_last)  state_nxt = S_DONE;
         end
         S_DONE: begin
            state_nxt = key_load ? S_RUN : S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---------------- output logic ----------------
   always_comb begin
      rk_valid   = (state == S_RUN);
      busy       = (state == S_RUN);
      done       = (state == S_DONE);
      last_round = (state == S_RUN) && (round_idx == LAST_IDX);
   end

   assign hs      = rk_valid & rk_ready;
   assign at_last = (round_idx == LAST_IDX);

   // Separate wrapping subkey counter so non-power-of-2 subkey counts work.
   assign sk_nxt = (sk_idx == LAST_SK) ? '0 : sk_idx + SK_W'(1);

   // Next round key candidates: on load the first subkey comes straight from
   // key_in (the subkey registers are being written in the same cycle).
   always_comb begin
      rk_load_nxt = key_in[KEY_W-1 -: RK_W];
      rk_step_nxt = sk[sk_nxt];
`ifdef FUTURE_RK_RC_EN
      // RC_i = i+1; round 0 uses 1, the next round after round_idx uses round_idx+2
      rk_load_nxt[CNT_W-1:0] = rk_load_nxt[CNT_W-1:0] ^ CNT_W'(1);
      rk_step_nxt[CNT_W-1:0] = rk_step_nxt[CNT_W-1:0] ^ (round_idx + CNT_W'(2));
`endif
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int j = 0; j < NUM_SUBKEYS; j++) sk[j] <= '0;
         sk_idx    <= '0;
         round_idx <= '0;
         rk_out    <= '0;
      end else if (key_load) begin
         for (int j = 0; j < NUM_SUBKEYS; j++) sk[j] <= key_in[KEY_W-1-j*RK_W -: RK_W];
         sk_idx    <= '0;
         round_idx <= '0;
         rk_out    <= rk_load_nxt;
      end else if (hs) begin
         if (at_last) begin
            round_idx <= '0;
            sk_idx    <= '0;
         end else begin
            round_idx <= round_idx + CNT_W'(1);
            sk_idx    <= sk_nxt;
            rk_out    <= rk_step_nxt;
         end
      end
   end

endmodule

// File: tb/tb_future_rk_sel.sv
// Purpose : self-checking bench for future_rk_sel with a queue-based scoreboard.
// Latency : expected keys are queued on the key_load edge and popped on each accepted handshake.
// Backpressure: rk_ready is randomised; held keys must stay equal to the scoreboard head.
module tb_future_rk_sel;

   localparam int KEY_W = 128;
   localparam int RK_W  = 64;
   localparam int NS    = 2;
   localparam int NR    = 10;
   localparam int CNT_W = $clog2(NR + 1);

   localparam logic [KEY_W-1:0] K = 128'h0123456789ABCDEF_FEDCBA9876543210;
`ifdef FUTURE_RK_RC_EN
   localparam logic [RK_W-1:0] RK0_EXP = 64'h0123456789ABCDEE;
`else
   localparam logic [RK_W-1:0] RK0_EXP = 64'h0123456789ABCDEF;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic [KEY_W-1:0] key_in;
   logic             key_load;
   logic             rk_ready;
   logic [RK_W-1:0]  rk_out;
   logic             rk_valid;
   logic [CNT_W-1:0] round_idx;
   logic             last_round;
   logic             done;
   logic             busy;

   future_rk_sel #(
      .KEY_W(KEY_W), .RK_W(RK_W), .NUM_SUBKEYS(NS), .NUM_ROUNDS(NR)
   ) dut (
      .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load),
      .rk_ready(rk_ready), .rk_out(rk_out), .rk_valid(rk_valid),
      .round_idx(round_idx), .last_round(last_round), .done(done), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [RK_W-1:0] rk;
      int              idx;
   } exp_t;

   exp_t q[$];
   exp_t mon_f;
   int   total = 0;
   int   bad   = 0;
   bit   mon_en = 1'b0;
   bit   exp_done = 1'b0;
   bit   exp_rk_zero = 1'b0;

   task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference: round key i is subkey (i mod NS), optionally XORed with i+1.
   function automatic logic [RK_W-1:0] model_rk(logic [KEY_W-1:0] key, int i);
      logic [RK_W-1:0] v;
      v = key[KEY_W-1-(i % NS)*RK_W -: RK_W];
`ifdef FUTURE_RK_RC_EN
      v = v ^ RK_W'(i + 1);
`endif
      return v;
   endfunction

   // Apply inputs for one clock edge, then update the expected-key queue.
   task automatic drive(bit r, bit kl, logic [KEY_W-1:0] k, bit rdy);
      rst      = r;
      key_load = kl;
      key_in   = k;
      rk_ready = rdy;
      @(posedge clk);
      if (r) begin
         q.delete();
         exp_rk_zero = 1'b1;
      end else if (kl) begin
         q.delete();
         exp_rk_zero = 1'b0;
         for (int i = 0; i < NR; i++) q.push_back('{model_rk(k, i), i});
      end
      #1;
   endtask

   // Monitor: compares outputs to the scoreboard head at each falling edge.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("rk_valid", 128'(rk_valid), 128'(q.size() != 0));
         chk("busy", 128'(busy), 128'(q.size() != 0));
         chk("done", 128'(done), 128'(exp_done));
         exp_done = 1'b0;
         if (exp_rk_zero) chk("rk_out_after_rst", 128'(rk_out), 128'(0));
         if (q.size() != 0) begin
            mon_f = q[0];
            chk("rk_out", 128'(rk_out), 128'(mon_f.rk));
            chk("round_idx", 128'(round_idx), 128'(mon_f.idx));
            chk("last_round", 128'(last_round), 128'(mon_f.idx == NR - 1));
            // accepted on the coming edge unless a reset or reload overrides it
            if (rk_ready && !key_load && !rst) begin
               void'(q.pop_front());
               if (mon_f.idx == NR - 1) exp_done = 1'b1;
            end
         end else begin
            chk("round_idx_idle", 128'(round_idx), 128'(0));
            chk("last_round_idle", 128'(last_round), 128'(0));
         end
      end
   end

   initial begin
      rst = 1'b1; key_load = 1'b0; key_in = K; rk_ready = 1'b0;
      drive(1'b1, 1'b0, K, 1'b0);
      drive(1'b1, 1'b0, K, 1'b1);
      mon_en = 1'b1;

      // reset state with a key present but no load
      repeat (10) drive(1'b0, 1'b0, K, ($urandom_range(0, 1) == 1));

      // full sequence, always ready
      drive(1'b0, 1'b1, K, 1'b1);
      chk("rk0_value", 128'(rk_out), 128'(RK0_EXP));
      repeat (NR + 2) drive(1'b0, 1'b0, K, 1'b1);

      // stall three cycles at round 4
      drive(1'b0, 1'b1, K, 1'b1);
      repeat (4) drive(1'b0, 1'b0, K, 1'b1);
      chk("stall_idx", 128'(round_idx), 128'(4));
      repeat (3) drive(1'b0, 1'b0, K, 1'b0);
      repeat (NR) drive(1'b0, 1'b0, K, 1'b1);

      // reload with zero key at round 6 while ready is high
      drive(1'b0, 1'b1, K, 1'b1);
      repeat (6) drive(1'b0, 1'b0, K, 1'b1);
      drive(1'b0, 1'b1, '0, 1'b1);
      repeat (NR + 2) drive(1'b0, 1'b0, K, 1'b1);

      // reset in mid-sequence at round 3, then restart
      drive(1'b0, 1'b1, K, 1'b1);
      repeat (3) drive(1'b0, 1'b0, K, 1'b1);
      drive(1'b1, 1'b0, K, 1'b1);
      repeat (3) drive(1'b0, 1'b0, K, 1'b1);
      drive(1'b0, 1'b1, K, 1'b1);
      repeat (NR + 2) drive(1'b0, 1'b0, K, 1'b1);

      // randomised traffic
      for (int c = 0; c < 4000; c++) begin
         drive(($urandom_range(0, 149) == 0),
               ($urandom_range(0, 11) == 0),
               {$urandom(), $urandom(), $urandom(), $urandom()},
               ($urandom_range(0, 9) < 7));
      end
      repeat (NR + 2) drive(1'b0, 1'b0, K, 1'b1);

      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
